// File: rtl/ram_cmd_arbiter.sv
// rtl/ram_cmd_arbiter.sv - two-port round-robin arbiter onto the single-port RAM command interface
//
// Accepts one transaction at a time from two requesters and turns it into the
// RAM's two-word command sequence. Reads then wait for the RAM's tx_valid
// window, capture the byte, and let the window drain before responding.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   req{0,1}_valid/_ready      request handshake (ready is combinational)
//   req{0,1}_wr/_addr/_wdata   request payload, held stable until accepted
//   rsp{0,1}_valid             one-cycle completion pulse per port
//   rsp_rdata, rsp_err         read byte / timeout flag, valid with rspX_valid
//   ram_din, ram_rx_valid      registered command word {opcode, payload} and strobe
//   ram_dout, ram_tx_valid     RAM read byte and its read-data window
//   busy                       high whenever a transaction is in flight

`timescale 1ns/1ps

module ram_cmd_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_wr,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [7:0]           req0_wdata,

  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_wr,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [7:0]           req1_wdata,

  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,

  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid,

  output logic                 busy
);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_CMD  = 2'b11;

  localparam logic [3:0] TIMEOUT_W = 4'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_ADDR,
    S_CMD_DATA,
    S_WAIT_TX,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   port_q, port_d;
  logic                   wr_q, wr_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [9:0]             din_q, din_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rsp0_q, rsp0_d;
  logic                   rsp1_q, rsp1_d;
  logic [7:0]             rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   grant0, grant1;
  logic                   can_accept;

  // A lone valid always wins; on a tie the port that was not granted last wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  // No grant while a (possibly stray) RAM read window is open: the RAM
  // ignores commands during it.
  assign can_accept = (state_q == S_IDLE) && !ram_tx_valid;

  assign req0_ready = can_accept && grant0;
  assign req1_ready = can_accept && grant1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    din_d        = din_q;
    rx_valid_d   = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          port_d       = req1_ready;
          last_grant_d = req1_ready;
          wr_d         = req1_ready ? req1_wr    : req0_wr;
          addr_d       = req1_ready ? req1_addr  : req0_addr;
          wdata_d      = req1_ready ? req1_wdata : req0_wdata;
          // Command outputs are registered, so the address word is loaded on
          // the handshake edge to appear during CMD_ADDR.
          rx_valid_d   = 1'b1;
          din_d        = {(wr_d ? OP_WR_ADDR : OP_RD_ADDR), addr_d};
          state_d      = S_CMD_ADDR;
        end
      end

      S_CMD_ADDR: begin
        rx_valid_d = 1'b1;
        din_d      = wr_q ? {OP_WR_DATA, wdata_q} : {OP_RD_CMD, 8'h00};
        state_d    = S_CMD_DATA;
      end

      S_CMD_DATA: begin
        if (wr_q) begin
          rdata_d = 8'h00;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d   = 4'd0;
          state_d = S_WAIT_TX;
        end
      end

      S_WAIT_TX: begin
        if (ram_tx_valid) begin
          rdata_d = ram_dout;
          err_d   = 1'b0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TIMEOUT_W) begin
            rdata_d = 8'h00;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_DRAIN: begin
        // Stay until the RAM closes its window so the next command is not lost.
        if (!ram_tx_valid) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response pulses are registered: raise them on the edge into RESP.
    rsp0_d = (state_d == S_RESP) && !port_q;
    rsp1_d = (state_d == S_RESP) &&  port_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 8'h00;
      cnt_q        <= 4'd0;
      din_q        <= 10'h000;
      rx_valid_q   <= 1'b0;
      rsp0_q       <= 1'b0;
      rsp1_q       <= 1'b0;
      rdata_q      <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      din_q        <= din_d;
      rx_valid_q   <= rx_valid_d;
      rsp0_q       <= rsp0_d;
      rsp1_q       <= rsp1_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign ram_din      = din_q;
  assign ram_rx_valid = rx_valid_q;
  assign rsp0_valid   = rsp0_q;
  assign rsp1_valid   = rsp1_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// tb/tb_ram_cmd_arbiter.sv - self-checking bench for ram_cmd_arbiter with a behavioural RAM and reference model

`timescale 1ns/1ps

module tb_ram_cmd_arbiter;

  localparam int LAT_WR = 3;
  localparam int LAT_RD = 12;
  localparam int TMO    = 15;
  localparam int LAT_TO = 3 + TMO;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_wr = 1'b0;
  logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00;
  logic       req1_valid = 1'b0, req1_wr = 1'b0;
  logic [7:0] req1_addr = 8'h00, req1_wdata = 8'h00;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid, rsp_err, busy;
  logic [7:0] rsp_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout = 8'h00;
  logic       ram_tx_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_cmd_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_wr      (req0_wr),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_wr      (req1_wr),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .rsp0_valid   (rsp0_valid),
    .rsp1_valid   (rsp1_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Behavioural RAM: address/data command pairs, 8-cycle read window.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_areg = 8'h00;
  int         tx_cnt = 0;
  bit         mem_init = 1'b0;
  logic       force_tx = 1'b0;
  logic       ram_mute = 1'b0;

  function automatic logic [7:0] mem_seed(input int a);
    return 8'(a * 37 + 5);
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= mem_seed(i);
      mem_init <= 1'b1;
    end
    if (ram_rx_valid && ram_din[9:8] == 2'b11 && !ram_mute) begin
      tx_cnt   <= 8;
      ram_dout <= ram_mem[ram_areg];
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
    end
    if (ram_rx_valid && ram_din[9:8] != 2'b11) begin
      if (ram_din[9:8] == 2'b01) ram_mem[ram_areg] <= ram_din[7:0];
      else                       ram_areg <= ram_din[7:0];
    end
  end

  assign ram_tx_valid = (tx_cnt != 0) || force_tx;

  // Reference model: one transaction in flight, fixed latencies, round robin.
  typedef struct {
    int         due;
    bit         port;
    logic [7:0] rdata;
    bit         err;
  } exp_t;

  exp_t       exp_q[$];
  int         act_grants[$];
  logic [7:0] ref_mem [int];
  bit         m_last = 1'b1;
  int         m_free = 0;
  int         m_hs   = -100;
  logic       m_wr   = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wdata = 8'h00;

  function automatic logic [7:0] ref_rd(input logic [7:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : mem_seed(int'(a));
  endfunction

  always @(negedge clk) begin : mon
    bit         idle, e_r0, e_r1;
    logic [9:0] w;
    exp_t       e;
    if (!rst_n) begin
      exp_q.delete();
      m_last = 1'b1;
      m_free = cyc + 1;
      m_hs   = -100;
    end else begin
      idle = (cyc >= m_free);
      e_r0 = idle && !ram_tx_valid && req0_valid && (!req1_valid || m_last);
      e_r1 = idle && !ram_tx_valid && req1_valid && (!req0_valid || !m_last);
      check("req0_ready", req0_ready, e_r0);
      check("req1_ready", req1_ready, e_r1);
      check("busy", busy, !idle);

      if (cyc == m_hs + 1) begin
        w = {(m_wr ? 2'b00 : 2'b10), m_addr};
        check("cmd_addr_strobe", ram_rx_valid, 1);
        check("cmd_addr_word", ram_din, w);
      end else if (cyc == m_hs + 2) begin
        w = m_wr ? {2'b01, m_wdata} : 10'h300;
        check("cmd_data_strobe", ram_rx_valid, 1);
        check("cmd_data_word", ram_din, w);
      end else begin
        check("no_cmd_strobe", ram_rx_valid, 0);
      end

      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("rsp0_valid", rsp0_valid, !e.port);
        check("rsp1_valid", rsp1_valid, e.port);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
      end else begin
        check("rsp0_idle", rsp0_valid, 0);
        check("rsp1_idle", rsp1_valid, 0);
      end

      if (req0_valid && req0_ready) act_grants.push_back(0);
      if (req1_valid && req1_ready) act_grants.push_back(1);

      if (e_r0 || e_r1) begin
        m_wr    = e_r1 ? req1_wr : req0_wr;
        m_addr  = e_r1 ? req1_addr : req0_addr;
        m_wdata = e_r1 ? req1_wdata : req0_wdata;
        e.port  = e_r1;
        if (m_wr) begin
          e.due = cyc + LAT_WR; e.rdata = 8'h00; e.err = 1'b0;
          ref_mem[int'(m_addr)] = m_wdata;
        end else if (ram_mute) begin
          e.due = cyc + LAT_TO; e.rdata = 8'h00; e.err = 1'b1;
        end else begin
          e.due = cyc + LAT_RD; e.rdata = ref_rd(m_addr); e.err = 1'b0;
        end
        exp_q.push_back(e);
        m_hs   = cyc;
        m_last = e_r1;
        m_free = e.due + 1;
      end
    end
  end

  task automatic drive(input bit port, input bit wr, input logic [7:0] addr, input logic [7:0] wd);
    int n = 0;
    if (port) begin
      req1_valid = 1'b1; req1_wr = wr; req1_addr = addr; req1_wdata = wd;
    end else begin
      req0_valid = 1'b1; req0_wr = wr; req0_addr = addr; req0_wdata = wd;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? req1_ready : req0_ready) && n < 300);
    if (n >= 300) check("ready_timeout", port ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 200);
    if (n >= 200) check("idle_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_port(input bit port, input int count);
    for (int k = 0; k < count; k++) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin @(posedge clk); #1; end
      drive(port, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)), 8'($urandom));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ram_din", ram_din, 0);
    check("reset_rx_valid", ram_rx_valid, 0);
    check("reset_rdata", rsp_rdata, 0);
    check("reset_err", rsp_err, 0);
    check("reset_busy", busy, 0);
    @(posedge clk); #1;

    // Write then read back the same location from port 0.
    drive(0, 1'b1, 8'h3C, 8'hA5);
    wait_idle();
    drive(0, 1'b0, 8'h3C, 8'h00);
    wait_idle();

    // Both ports kept busy: grants must alternate.
    act_grants.delete();
    fork
      begin drive(0, 1'b1, 8'h10, 8'h11); drive(0, 1'b1, 8'h10, 8'h11); end
      begin @(posedge clk); #1; drive(1, 1'b1, 8'h20, 8'h22); drive(1, 1'b1, 8'h20, 8'h22); end
    join
    wait_idle();
    check("grant_count", act_grants.size(), 4);
    if (act_grants.size() == 4) begin
      check("grant_0", act_grants[0], 0);
      check("grant_1", act_grants[1], 1);
      check("grant_2", act_grants[2], 0);
      check("grant_3", act_grants[3], 1);
    end

    // Read with no RAM answer: timeout, then a normal request.
    ram_mute = 1'b1;
    drive(1, 1'b0, 8'h42, 8'h00);
    wait_idle();
    ram_mute = 1'b0;
    drive(0, 1'b1, 8'h43, 8'h99);
    wait_idle();

    // Stray read window while idle blocks the grant.
    force_tx = 1'b1;
    fork
      drive(1, 1'b1, 8'h44, 8'h5E);
      begin
        repeat (6) begin @(negedge clk); check("req1_ready_forced", req1_ready, 0); end
        @(posedge clk); #1 force_tx = 1'b0;
      end
    join
    wait_idle();

    // Randomised traffic from both ports.
    fork
      rand_port(0, 15);
      rand_port(1, 15);
    join
    wait_idle();

    // Reset during DRAIN of a port-0 read; port 0 must win the next tie.
    drive(0, 1'b0, 8'h3C, 8'h00);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rsp0", rsp0_valid, 0);
    check("rst_mid_rsp1", rsp1_valid, 0);
    check("rst_mid_ram_din", ram_din, 0);
    check("rst_mid_rx_valid", ram_rx_valid, 0);
    check("rst_mid_rdata", rsp_rdata, 0);
    check("rst_mid_err", rsp_err, 0);
    @(posedge clk); #1;
    act_grants.delete();
    fork
      drive(0, 1'b1, 8'h55, 8'h66);
      drive(1, 1'b1, 8'h56, 8'h77);
    join
    wait_idle();
    check("post_reset_grants", act_grants.size(), 2);
    if (act_grants.size() == 2) check("post_reset_first", act_grants[0], 0);

    repeat (3) @(posedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
Arbitrates two independent requesters (port 0, port 1) onto the single 10-bit command interface of the single-port RAM. Each accepted transaction is converted into the RAM's two-word command sequence. Read transactions additionally wait for the RAM's tx_valid window, capture the read byte and return it. Sits between the SPI-side requester and a local requester (e.g. BIST/host) and the RAM.

Parameters:
ADDR_SIZE, 8, address width; fixed at 8 (RAM command word is 2-bit opcode + 8-bit payload)
TIMEOUT, 15, max cycles spent in WAIT_TX before a read is aborted with error; counter width 4 bits, legal 1..15

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  port 0 transaction request
req0_ready  out  1  port 0 accept; handshake = valid & ready
req0_wr  in  1  1 = write, 0 = read
req0_addr  in  ADDR_SIZE  target address
req0_wdata  in  8  write data (ignored for reads)
req1_valid, req1_ready, req1_wr, req1_addr, req1_wdata  same as port 0, for port 1
rsp0_valid  out  1  one-cycle completion pulse for port 0
rsp1_valid  out  1  one-cycle completion pulse for port 1
rsp_rdata  out  8  read data, valid with rspX_valid (0 for writes and errors)
rsp_err  out  1  timeout flag, valid with rspX_valid
ram_din  out  10  command word to RAM {opcode[1:0], payload[7:0]}
ram_rx_valid  out  1  command strobe to RAM
ram_dout  in  8  RAM read data
ram_tx_valid  in  1  RAM read-data window
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; ram_din=0, ram_rx_valid=0, rsp0/1_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0, last_grant=1 (port 0 wins first tie). Any in-flight transaction is dropped with no response. Reset mid-operation behaves identically.
- reqX_ready is combinational: high only when state==IDLE, ram_tx_valid==0, reqX_valid==1 and port X is the winner. At most one ready high per cycle.
- Arbitration: if only one valid, it wins. If both valid, winner = port != last_grant (round robin). last_grant updates on handshake only.
- Requesters hold valid and payload stable until ready; valid is not withdrawn before handshake.
- Handshake edge: wr, addr, wdata and port id are captured; state -> CMD_ADDR.
- CMD_ADDR (1 cycle): ram_rx_valid=1, ram_din={wr?2'b00:2'b10, addr}. -> CMD_DATA.
- CMD_DATA (1 cycle): ram_rx_valid=1, ram_din = wr ? {2'b01, wdata} : {2'b11, 8'h00}. Write -> RESP; read -> WAIT_TX, counter cleared.
- ram_din/ram_rx_valid are registered; ram_rx_valid=0 and ram_din holds its last value outside CMD states.
- WAIT_TX: if ram_tx_valid=1, capture ram_dout into rsp_rdata -> DRAIN. Otherwise counter++; when counter reaches TIMEOUT -> RESP with rsp_err=1, rsp_rdata=0.
- DRAIN: remain while ram_tx_valid=1 (RAM ignores commands during its 8-cycle window). First cycle with ram_tx_valid=0 -> RESP.
- RESP (1 cycle): rspX_valid=1 for the captured port, with rsp_rdata/rsp_err. -> IDLE. Writes: rsp_rdata=0, rsp_err=0.
- Latency (handshake in cycle 0): write rsp in cycle 3, next handshake possible in cycle 4. Read against the RAM: tx_valid in cycles 3..10, data captured at end of cycle 3, rsp in cycle 12.
- ram_tx_valid high while IDLE (stray/late window): no grant until it drops.
- New requests arriving while busy wait; no queuing beyond the held valid.

Test Plan:
- Port 0 writes addr 0x3C data 0xA5 -> ram_din 0x03C then 0x1A5 on consecutive cycles, rsp0_valid in cycle 3, rsp_err=0.
- Port 0 reads 0x3C (after the write above) -> ram_din 0x23C, 0x300; rsp0_valid in cycle 12 with rsp_rdata=0xA5, rsp_err=0; no ram_rx_valid during the tx_valid window.
- Both ports valid continuously (p0 write 0x10/0x11, p1 write 0x20/0x22) -> grants alternate p0, p1, p0, p1; each rsp pulse goes to the correct port.
- Read with ram_tx_valid tied 0 -> rsp_err=1, rsp_rdata=0 after 15 WAIT_TX cycles; arbiter returns to IDLE and accepts the next request.
- ram_tx_valid forced high in IDLE with req1_valid=1 -> req1_ready stays 0 until tx_valid drops, then handshake.
- rst_n low for 1 cycle in the middle of DRAIN -> all outputs 0, no rsp pulse, busy=0; next request from port 0 is served first.
